tilelink_n_to_1: RTL and testbench
==================================

// Module: tilelink_n_to_1
// PURPOSE
//  N-master to 1-slave TileLink-UL arbiter/mux; counterpart of the 1-to-N address decoder.
//  A channel: round-robin arbitration, grant locked for multi-beat Put bursts, registered output.
//  D channel: responses routed back to the owning master via source bits added on A; registered per master.
//  Sits between several initiators (core ports, DMA) and one shared slave or decoder input.
// PARAMETERS
//  N      2   number of masters (>=2); MW = $clog2(N) master-index bits
//  TL_DW  32  data width, bits (power of two, >=32)
//  TL_AW  32  address width
//  TL_RS  4   master-side source width; slave-side source width = TL_RS+MW
//  TL_SZ  4   size field width
// PORTS
//  tilelink_clock_i  in   1  clock, all logic on rising edge
//  tilelink_reset_ni in   1  synchronous reset, active-low
//  master_a_{opcode,param} in N*3; master_a_size in N*TL_SZ; master_a_source in N*TL_RS
//  master_a_address in N*TL_AW; master_a_mask in N*TL_DW/8; master_a_data in N*TL_DW; master_a_corrupt in N
//  master_a_valid in N / master_a_ready out N  per-master A handshake
//  master_d_opcode out N*3; master_d_param out N*2; master_d_size out N*TL_SZ; master_d_source out N*TL_RS
//  master_d_denied,master_d_corrupt out N; master_d_data out N*TL_DW; master_d_valid out N / master_d_ready in N
//  slave_a_{opcode,param} out 3; slave_a_size out TL_SZ; slave_a_source out TL_RS+MW; slave_a_address out TL_AW
//  slave_a_mask out TL_DW/8; slave_a_data out TL_DW; slave_a_corrupt out 1; slave_a_valid out 1 / slave_a_ready in 1
//  slave_d_{opcode 3,param 2,size TL_SZ,source TL_RS+MW,denied 1,data TL_DW,corrupt 1} in; slave_d_valid in / slave_d_ready out
// BEHAVIOUR
//  Reset (tilelink_reset_ni=0 at edge): slave_a_valid=0, master_d_valid=0, state=IDLE, rr_ptr=0, beat_cnt=0, grant=none.
//   Data outputs don't-care under reset; reset mid-burst abandons the burst, no further beats issued.
//  Slave A stage: one register. a_free = !slave_a_valid | slave_a_ready.
//   master_a_ready[i] = grant[i] & a_free; fire = master_a_valid[g] & master_a_ready[g].
//   On fire: register all A fields of g, slave_a_source = {g[MW-1:0], master_a_source[g]}, slave_a_valid=1.
//   Else if slave_a_ready: slave_a_valid=0. Latency master->slave 1 cycle; throughput 1 beat/cycle.
//  Arbitration, IDLE: grant = first i with master_a_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N (combinational).
//   Beats: opcode PutFull(0)/PutPartial(1) with size>log2(TL_DW/8) and size<=12 -> 2^size/(TL_DW/8); all else 1.
//   Fire of 1-beat msg: stay IDLE, rr_ptr=(g+1) mod N. Fire of first beat of k-beat msg: ->BURST, lock g, beat_cnt=k-1.
//  BURST: grant forced to locked g only, other masters ready=0. Each fire: beat_cnt--.
//   Fire with beat_cnt==1: ->IDLE, rr_ptr=(g+1) mod N. Locked master deasserting valid mid-burst: wait, no switch.
//  No master valid in IDLE: no grant, rr_ptr unchanged.
//  D path: dest k = slave_d_source[TL_RS+MW-1:TL_RS]; k>=N (non-power-of-2 N) -> response dropped (ready=1, no forward).
//   Per-master D register k: d_free[k] = !master_d_valid[k] | master_d_ready[k]; slave_d_ready = d_free[dest].
//   On slave_d_valid & slave_d_ready: register fields into master k, master_d_source = low TL_RS bits, valid=1.
//   Master with valid & ready and no new load: valid=0. Latency slave->master 1 cycle. D beats never reordered.
//  D is fully independent of A state; AccessAck/AccessAckData bursts pass beat by beat, no D-side locking needed.
// TESTING
//  1: M0 Get addr 0x100 src 3, slave ready -> next cycle slave_a_valid=1, source={0,3}; D AccessAckData src {0,3} -> master_d_valid[0]=1, src 3.
//  2: M0,M1 valid Gets continuously, rr_ptr=0 -> grants alternate 0,1,0,1 on 4 consecutive fires.
//  3: TL_DW=32, M1 PutFull size 4 (4 beats), M0 valid throughout -> 4 consecutive M1 beats, then M0 granted.
//  4: slave_a_ready=0 for 3 cycles with beat registered -> slave_a fields stable, master_a_ready=0, no beat lost or duplicated.
//  5: D to M1 while master_d_ready[1]=0 and valid held -> slave_d_ready=0 until M1 accepts; M0 D unaffected.
//  6: reset asserted on beat 2 of 4-beat Put -> after reset slave_a_valid=0, IDLE, rr_ptr=0, next grant M0 if valid.

Source files
------------

// File: rtl/tilelink_n_to_1.sv
// tilelink_n_to_1: N-master to 1-slave TileLink-UL arbiter/mux.
// A channel: round-robin grant, locked for multi-beat Put bursts, one output register.
// D channel: responses steered back by the master-index bits prepended to source.
module tilelink_n_to_1 #(
  parameter int N     = 2,
  parameter int TL_DW = 32,
  parameter int TL_AW = 32,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4,
  localparam int MW   = $clog2(N),
  localparam int MB   = TL_DW / 8,
  localparam int SW   = TL_RS + MW
) (
  input  logic                  tilelink_clock_i,
  input  logic                  tilelink_reset_ni,
  // master-side A
  input  logic [N*3-1:0]        master_a_opcode,
  input  logic [N*3-1:0]        master_a_param,
  input  logic [N*TL_SZ-1:0]    master_a_size,
  input  logic [N*TL_RS-1:0]    master_a_source,
  input  logic [N*TL_AW-1:0]    master_a_address,
  input  logic [N*MB-1:0]       master_a_mask,
  input  logic [N*TL_DW-1:0]    master_a_data,
  input  logic [N-1:0]          master_a_corrupt,
  input  logic [N-1:0]          master_a_valid,
  output logic [N-1:0]          master_a_ready,
  // master-side D
  output logic [N*3-1:0]        master_d_opcode,
  output logic [N*2-1:0]        master_d_param,
  output logic [N*TL_SZ-1:0]    master_d_size,
  output logic [N*TL_RS-1:0]    master_d_source,
  output logic [N-1:0]          master_d_denied,
  output logic [N*TL_DW-1:0]    master_d_data,
  output logic [N-1:0]          master_d_corrupt,
  output logic [N-1:0]          master_d_valid,
  input  logic [N-1:0]          master_d_ready,
  // slave-side A
  output logic [2:0]            slave_a_opcode,
  output logic [2:0]            slave_a_param,
  output logic [TL_SZ-1:0]      slave_a_size,
  output logic [SW-1:0]         slave_a_source,
  output logic [TL_AW-1:0]      slave_a_address,
  output logic [MB-1:0]         slave_a_mask,
  output logic [TL_DW-1:0]      slave_a_data,
  output logic                  slave_a_corrupt,
  output logic                  slave_a_valid,
  input  logic                  slave_a_ready,
  // slave-side D
  input  logic [2:0]            slave_d_opcode,
  input  logic [1:0]            slave_d_param,
  input  logic [TL_SZ-1:0]      slave_d_size,
  input  logic [SW-1:0]         slave_d_source,
  input  logic                  slave_d_denied,
  input  logic [TL_DW-1:0]      slave_d_data,
  input  logic                  slave_d_corrupt,
  input  logic                  slave_d_valid,
  output logic                  slave_d_ready
);

  localparam int LOG_MB = $clog2(MB);
  localparam int CW     = 13;  // holds up to 4096-byte bursts at the narrowest bus

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg, state_next;
  logic [MW-1:0]   rr_reg, rr_next;
  logic [MW-1:0]   lock_reg, lock_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic            gnt_found;
  logic [MW-1:0]   gnt_idx;
  logic [MW-1:0]   gnt_inc;
  logic [MW-1:0]   scan_idx;
  logic            a_free;
  logic            fire;
  logic [CW-1:0]   sel_beats;

  // per-master views of the flattened A buses
  logic [2:0]       a_opcode  [N];
  logic [2:0]       a_param   [N];
  logic [TL_SZ-1:0] a_size    [N];
  logic [TL_RS-1:0] a_source  [N];
  logic [TL_AW-1:0] a_address [N];
  logic [MB-1:0]    a_mask    [N];
  logic [TL_DW-1:0] a_data    [N];

  logic [MW-1:0]    d_dest;
  logic [N-1:0]     d_hit;
  logic [N-1:0]     d_free;

  genvar gi;

  generate
    for (gi = 0; gi < N; gi++) begin : g_a_unpack
      assign a_opcode[gi]  = master_a_opcode[gi*3 +: 3];
      assign a_param[gi]   = master_a_param[gi*3 +: 3];
      assign a_size[gi]    = master_a_size[gi*TL_SZ +: TL_SZ];
      assign a_source[gi]  = master_a_source[gi*TL_RS +: TL_RS];
      assign a_address[gi] = master_a_address[gi*TL_AW +: TL_AW];
      assign a_mask[gi]    = master_a_mask[gi*MB +: MB];
      assign a_data[gi]    = master_a_data[gi*TL_DW +: TL_DW];
      assign master_a_ready[gi] = gnt_found & (gnt_idx == MW'(gi)) & a_free;
    end
  endgenerate

  assign a_free  = !slave_a_valid | slave_a_ready;
  assign fire    = gnt_found & master_a_valid[gnt_idx] & a_free;
  assign gnt_inc = (gnt_idx == MW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  // Grant: locked master during a burst, otherwise first valid master from rr pointer
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (state_reg == BURST) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_reg;
    end else begin
      for (int off = 0; off < N; off++) begin
        scan_idx = MW'((int'(rr_reg) + off) % N);
        if (!gnt_found && master_a_valid[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = scan_idx;
        end
      end
    end
  end

  // Beat count of the granted message: multi-beat only for Put wider than the bus
  always_comb begin
    sel_beats = CW'(1);
    if ((a_opcode[gnt_idx] == 3'd0 || a_opcode[gnt_idx] == 3'd1) &&
        int'(a_size[gnt_idx]) > LOG_MB && int'(a_size[gnt_idx]) <= 12) begin
      sel_beats = CW'(1) << (int'(a_size[gnt_idx]) - LOG_MB);
    end
  end

  // Arbiter state register
  always_ff @(posedge tilelink_clock_i) begin
    if (!tilelink_reset_ni) begin
      state_reg <= IDLE;
      rr_reg    <= '0;
      lock_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      lock_reg  <= lock_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Arbiter next state: enter BURST on a multi-beat head, leave on its last beat
  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    lock_next  = lock_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (fire) begin
          if (sel_beats > CW'(1)) begin
            state_next = BURST;
            lock_next  = gnt_idx;
            cnt_next   = sel_beats - CW'(1);
          end else begin
            rr_next = gnt_inc;
          end
        end
      end
      BURST: begin
        if (fire) begin
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_next = IDLE;
            rr_next    = gnt_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave A valid: set on a fire, cleared once the slave takes the beat
  always_ff @(posedge tilelink_clock_i) begin
    if (!tilelink_reset_ni) begin
      slave_a_valid <= 1'b0;
    end else if (fire) begin
      slave_a_valid <= 1'b1;
    end else if (slave_a_ready) begin
      slave_a_valid <= 1'b0;
    end
  end

  // Slave A payload: captured from the granted master, tagged with its index
  always_ff @(posedge tilelink_clock_i) begin
    if (fire) begin
      slave_a_opcode  <= a_opcode[gnt_idx];
      slave_a_param   <= a_param[gnt_idx];
      slave_a_size    <= a_size[gnt_idx];
      slave_a_source  <= {gnt_idx, a_source[gnt_idx]};
      slave_a_address <= a_address[gnt_idx];
      slave_a_mask    <= a_mask[gnt_idx];
      slave_a_data    <= a_data[gnt_idx];
      slave_a_corrupt <= master_a_corrupt[gnt_idx];
    end
  end

  assign d_dest = slave_d_source[SW-1:TL_RS];
  // An index with no matching master (non-power-of-two N) is accepted and dropped
  assign slave_d_ready = (|d_hit) ? |(d_hit & d_free) : 1'b1;

  generate
    for (gi = 0; gi < N; gi++) begin : g_d
      logic             valid_reg;
      logic [2:0]       opcode_reg;
      logic [1:0]       param_reg;
      logic [TL_SZ-1:0] size_reg;
      logic [TL_RS-1:0] source_reg;
      logic             denied_reg;
      logic [TL_DW-1:0] data_reg;
      logic             corrupt_reg;
      logic             load;

      assign d_hit[gi]  = (d_dest == MW'(gi));
      assign d_free[gi] = !valid_reg | master_d_ready[gi];
      assign load       = slave_d_valid & d_hit[gi] & d_free[gi];

      // Per-master D valid: loaded from the slave, drained by the master
      always_ff @(posedge tilelink_clock_i) begin
        if (!tilelink_reset_ni) begin
          valid_reg <= 1'b0;
        end else if (load) begin
          valid_reg <= 1'b1;
        end else if (master_d_ready[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      // Per-master D payload, master index stripped from source
      always_ff @(posedge tilelink_clock_i) begin
        if (load) begin
          opcode_reg  <= slave_d_opcode;
          param_reg   <= slave_d_param;
          size_reg    <= slave_d_size;
          source_reg  <= slave_d_source[TL_RS-1:0];
          denied_reg  <= slave_d_denied;
          data_reg    <= slave_d_data;
          corrupt_reg <= slave_d_corrupt;
        end
      end

      assign master_d_valid[gi]                   = valid_reg;
      assign master_d_opcode[gi*3 +: 3]           = opcode_reg;
      assign master_d_param[gi*2 +: 2]            = param_reg;
      assign master_d_size[gi*TL_SZ +: TL_SZ]     = size_reg;
      assign master_d_source[gi*TL_RS +: TL_RS]   = source_reg;
      assign master_d_denied[gi]                  = denied_reg;
      assign master_d_data[gi*TL_DW +: TL_DW]     = data_reg;
      assign master_d_corrupt[gi]                 = corrupt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tilelink_n_to_1.sv
// Testbench for tilelink_n_to_1 (N=2, 32-bit data): scoreboard on A and D paths.
module tb_tilelink_n_to_1;

  localparam int N = 2;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [4:0]  src;
    logic [2:0]  op;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } abeat_t;

  typedef struct {
    logic [4:0]  src;
    logic [2:0]  op;
    logic [31:0] data;
  } dbeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  ma_opcode = '0, ma_param = '0;
  logic [7:0]  ma_size = '0, ma_source = '0, ma_mask = '0;
  logic [63:0] ma_address = '0, ma_data = '0;
  logic [1:0]  ma_corrupt = '0, ma_valid = '0, ma_ready;
  logic [5:0]  md_opcode;
  logic [3:0]  md_param;
  logic [7:0]  md_size, md_source;
  logic [1:0]  md_denied, md_corrupt, md_valid;
  logic [63:0] md_data;
  logic [1:0]  md_ready = '0;
  logic [2:0]  sa_opcode, sa_param;
  logic [3:0]  sa_size;
  logic [4:0]  sa_source;
  logic [31:0] sa_address, sa_data;
  logic [3:0]  sa_mask;
  logic        sa_corrupt, sa_valid;
  logic        sa_ready = 1'b0;
  logic [2:0]  sd_opcode = '0;
  logic [1:0]  sd_param = '0;
  logic [3:0]  sd_size = 4'd2;
  logic [4:0]  sd_source = '0;
  logic        sd_denied = 1'b0, sd_corrupt = 1'b0, sd_valid = 1'b0, sd_ready;
  logic [31:0] sd_data = '0;

  tilelink_n_to_1 #(.N(2), .TL_DW(32), .TL_AW(32), .TL_RS(4), .TL_SZ(4)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_ni(rst_n),
    .master_a_opcode  (ma_opcode),
    .master_a_param   (ma_param),
    .master_a_size    (ma_size),
    .master_a_source  (ma_source),
    .master_a_address (ma_address),
    .master_a_mask    (ma_mask),
    .master_a_data    (ma_data),
    .master_a_corrupt (ma_corrupt),
    .master_a_valid   (ma_valid),
    .master_a_ready   (ma_ready),
    .master_d_opcode  (md_opcode),
    .master_d_param   (md_param),
    .master_d_size    (md_size),
    .master_d_source  (md_source),
    .master_d_denied  (md_denied),
    .master_d_data    (md_data),
    .master_d_corrupt (md_corrupt),
    .master_d_valid   (md_valid),
    .master_d_ready   (md_ready),
    .slave_a_opcode   (sa_opcode),
    .slave_a_param    (sa_param),
    .slave_a_size     (sa_size),
    .slave_a_source   (sa_source),
    .slave_a_address  (sa_address),
    .slave_a_mask     (sa_mask),
    .slave_a_data     (sa_data),
    .slave_a_corrupt  (sa_corrupt),
    .slave_a_valid    (sa_valid),
    .slave_a_ready    (sa_ready),
    .slave_d_opcode   (sd_opcode),
    .slave_d_param    (sd_param),
    .slave_d_size     (sd_size),
    .slave_d_source   (sd_source),
    .slave_d_denied   (sd_denied),
    .slave_d_data     (sd_data),
    .slave_d_corrupt  (sd_corrupt),
    .slave_d_valid    (sd_valid),
    .slave_d_ready    (sd_ready)
  );

  // stimulus and scoreboard state
  beat_t  mq0[$], mq1[$];
  abeat_t exp_a[$];
  dbeat_t sdq[$], exp_d0[$], exp_d1[$];
  int     glog[$];
  bit     sar_pat[$];
  logic [1:0] en = 2'b11, d_rdy = 2'b11;
  bit     rand_ar = 0, rand_dr = 0;

  // reference arbiter model
  bit         m_burst;
  int         m_rr, m_lock, m_cnt;
  bit         m_sav;
  logic [1:0] m_mdv;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int beats_of(input logic [2:0] op, input logic [3:0] size);
    if ((op == 3'd0 || op == 3'd1) && size > 4'd2 && size <= 4'd12) return 1 << (size - 4'd2);
    return 1;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic beat_t head(input int i);
    return (i == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qpush(input int i, input beat_t b);
    if (i == 0) mq0.push_back(b); else mq1.push_back(b);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic push_msg(input int m, input logic [2:0] op, input logic [3:0] size,
                          input logic [3:0] src, input logic [31:0] addr);
    beat_t b;
    int k = beats_of(op, size);
    for (int j = 0; j < k; j++) begin
      b.op = op; b.size = size; b.src = src; b.addr = addr;
      b.data = addr ^ {m[3:0], 20'h0, 8'(j)} ^ 32'h5A5A_0000;
      qpush(m, b);
    end
  endtask

  task automatic push_d(input logic [4:0] src, input logic [31:0] data);
    dbeat_t d;
    d.src = src; d.op = 3'd1; d.data = data;
    sdq.push_back(d);
  endtask

  function automatic bit busy();
    return (mq0.size() + mq1.size() + exp_a.size() + sdq.size() + exp_d0.size() + exp_d1.size()) != 0
           || m_sav || (m_mdv != 2'b00);
  endfunction

  // One clock: drive at negedge, check and update the model, then wait for posedge
  task automatic cycle();
    beat_t b;
    abeat_t e;
    dbeat_t d;
    bit found, fire, a_free, exp_sdr, load;
    int g, idx, dest;
    logic [1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (en[i] && qsize(i) > 0) begin
        b = head(i);
        ma_valid[i] = 1'b1;
        ma_opcode[i*3 +: 3] = b.op;
        ma_param[i*3 +: 3] = 3'd0;
        ma_size[i*4 +: 4] = b.size;
        ma_source[i*4 +: 4] = b.src;
        ma_address[i*32 +: 32] = b.addr;
        ma_data[i*32 +: 32] = b.data;
        ma_mask[i*4 +: 4] = 4'hF;
        ma_corrupt[i] = 1'b0;
      end else begin
        ma_valid[i] = 1'b0;
      end
    end
    if (sar_pat.size() > 0) sa_ready = sar_pat.pop_front();
    else if (rand_ar) sa_ready = 1'($urandom_range(0, 1));
    else sa_ready = 1'b1;
    md_ready = rand_dr ? 2'($urandom_range(0, 3)) : d_rdy;
    if (sdq.size() > 0) begin
      sd_valid = 1'b1; sd_source = sdq[0].src; sd_opcode = sdq[0].op; sd_data = sdq[0].data;
    end else begin
      sd_valid = 1'b0;
    end
    #1;
    // A channel
    a_free = !m_sav || sa_ready;
    found = 0; g = 0;
    if (m_burst) begin
      found = 1; g = m_lock;
    end else begin
      for (int off = 0; off < N; off++) begin
        idx = (m_rr + off) % N;
        if (!found && ma_valid[idx]) begin found = 1; g = idx; end
      end
    end
    exp_rdy = (found && a_free) ? 2'(1 << g) : 2'b00;
    check("a_ready", ma_ready, exp_rdy);
    check("a_valid", sa_valid, m_sav);
    if (sa_valid && sa_ready) begin
      if (exp_a.size() == 0) begin
        check("a_extra_beat", sa_valid, 0);
      end else begin
        e = exp_a.pop_front();
        check("a_source", sa_source, e.src);
        check("a_opcode", sa_opcode, e.op);
        check("a_size", sa_size, e.size);
        check("a_address", sa_address, e.addr);
        check("a_data", sa_data, e.data);
        check("a_mask", sa_mask, 4'hF);
        $display("A beat src=%h op=%0d addr=%h data=%h", sa_source, sa_opcode, sa_address, sa_data);
      end
    end
    fire = found && a_free && ma_valid[g];
    if (fire) begin
      b = head(g);
      e.src = {g[0], b.src}; e.op = b.op; e.size = b.size; e.addr = b.addr; e.data = b.data;
      exp_a.push_back(e);
      if (m_burst) begin
        if (m_cnt == 1) begin m_burst = 0; m_rr = (g + 1) % N; end
        m_cnt--;
      end else if (beats_of(b.op, b.size) > 1) begin
        m_burst = 1; m_lock = g; m_cnt = beats_of(b.op, b.size) - 1;
      end else begin
        m_rr = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ma_valid[i] && ma_ready[i]) begin qpop(i); glog.push_back(i); end
    end
    m_sav = fire ? 1'b1 : (sa_ready ? 1'b0 : m_sav);
    // D channel
    for (int k = 0; k < N; k++) check($sformatf("d_valid%0d", k), md_valid[k], m_mdv[k]);
    dest = int'(sd_source[4]);
    exp_sdr = !m_mdv[dest] || md_ready[dest];
    check("d_ready", sd_ready, exp_sdr);
    for (int k = 0; k < N; k++) begin
      if (md_valid[k] && md_ready[k]) begin
        if ((k == 0 ? exp_d0.size() : exp_d1.size()) == 0) begin
          check("d_extra_beat", md_valid[k], 0);
        end else begin
          d = (k == 0) ? exp_d0.pop_front() : exp_d1.pop_front();
          check("d_source", md_source[k*4 +: 4], d.src[3:0]);
          check("d_opcode", md_opcode[k*3 +: 3], d.op);
          check("d_data", md_data[k*32 +: 32], d.data);
          $display("D beat to M%0d src=%h data=%h", k, md_source[k*4 +: 4], md_data[k*32 +: 32]);
        end
      end
    end
    load = sd_valid && exp_sdr;
    if (sd_valid && sd_ready) void'(sdq.pop_front());
    if (load) begin
      d.src = sd_source; d.op = sd_opcode; d.data = sd_data;
      if (dest == 0) exp_d0.push_back(d); else exp_d1.push_back(d);
    end
    for (int k = 0; k < N; k++) begin
      if (load && dest == k) m_mdv[k] = 1'b1;
      else if (md_ready[k]) m_mdv[k] = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while (busy() && c < limit) begin cycle(); c++; end
    check("drain_timeout", 64'(busy()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ma_valid = '0;
    sd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_valid", sa_valid, 0);
    check("rst_d_valid", md_valid, 0);
    mq0.delete(); mq1.delete(); exp_a.delete(); sdq.delete();
    exp_d0.delete(); exp_d1.delete(); sar_pat.delete();
    m_burst = 0; m_rr = 0; m_lock = 0; m_cnt = 0; m_sav = 0; m_mdv = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    do_reset();

    // single Get from M0 and its AccessAckData
    push_msg(0, 3'd4, 4'd2, 4'd3, 32'h100);
    push_d(5'h03, 32'hCAFE_0100);
    drain(100);

    // round robin between two always-valid masters
    do_reset();
    glog.delete();
    for (int j = 0; j < 4; j++) begin
      push_msg(0, 3'd4, 4'd2, 4'(j), 32'h1000 + 32'(j * 4));
      push_msg(1, 3'd4, 4'd2, 4'(j), 32'h2000 + 32'(j * 4));
    end
    drain(200);
    for (int k = 0; k < 4; k++) check("rr_order", (k < glog.size()) ? 64'(glog[k]) : 64'hFF, 64'(k % 2));

    // 4-beat PutFull on M1 while M0 keeps requesting
    glog.delete();
    push_msg(1, 3'd0, 4'd4, 4'd7, 32'h300);
    for (int j = 0; j < 3; j++) push_msg(0, 3'd4, 4'd2, 4'd1, 32'h400 + 32'(j * 4));
    drain(200);
    begin
      int exp_seq[7] = '{0, 1, 1, 1, 1, 0, 0};
      for (int k = 0; k < 7; k++) check("burst_order", (k < glog.size()) ? 64'(glog[k]) : 64'hFF, 64'(exp_seq[k]));
    end

    // slave stalls for three cycles with a beat held
    sar_pat.push_back(1); sar_pat.push_back(0); sar_pat.push_back(0); sar_pat.push_back(0);
    push_msg(0, 3'd4, 4'd2, 4'd2, 32'h500);
    push_msg(0, 3'd4, 4'd2, 4'd3, 32'h504);
    drain(100);

    // D back-pressure from M1 must not disturb M0 delivery
    d_rdy = 2'b01;
    push_d(5'h12, 32'hD100_0001);
    push_d(5'h05, 32'hD000_0002);
    push_d(5'h13, 32'hD100_0003);
    repeat (8) cycle();
    d_rdy = 2'b11;
    drain(100);

    // reset during beat 2 of a 4-beat Put
    push_msg(1, 3'd0, 4'd4, 4'd9, 32'h600);
    c = 0;
    while (!(m_burst && m_cnt == 3) && c < 50) begin cycle(); c++; end
    check("burst_reached", 64'(m_burst), 1);
    do_reset();
    glog.delete();
    push_msg(1, 3'd4, 4'd2, 4'd1, 32'h700);
    push_msg(0, 3'd4, 4'd2, 4'd2, 32'h704);
    drain(100);
    check("post_reset_grant", (glog.size() > 0) ? 64'(glog[0]) : 64'hFF, 0);

    // mixed random traffic with random back-pressure on both channels
    rand_ar = 1; rand_dr = 1;
    for (int j = 0; j < 20; j++) begin
      for (int m = 0; m < N; m++) begin
        logic [2:0] op;
        case ($urandom_range(0, 2))
          0: op = 3'd0;
          1: op = 3'd1;
          default: op = 3'd4;
        endcase
        push_msg(m, op, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 32'($urandom) & 32'hFFFF_FFC0);
      end
      push_d(5'($urandom_range(0, 31)), $urandom);
    end
    drain(3000);
    rand_ar = 0; rand_dr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
